// File: rtl/htpa_spi_pkg.sv
// Shared definitions for the HTPA SPI frame sequencer.
//   - EEPROM opcode constants used to size the transmit phase
//   - target select encoding for the tgt input
//   - frame FSM state type
package htpa_spi_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam logic TGT_MTX = 1'b0;
  localparam logic TGT_EEP = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/htpa_spi_clkgen.sv
// SCLK generator: half-period counter producing a mode-0 clock.
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : run; when low the counter and sclk are held at 0
//   sclk       : SPI clock, idle low
//   rise/fall  : one-cycle strobes, high in the cycle whose closing edge
//                drives sclk high / low
module htpa_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == DW'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/htpa_spi_frame_seq.sv
// Self-timed SPI frame engine for the HTPA thermopile matrix and its
// configuration EEPROM. Serialises opcode/address/data MSB-first, drops
// MOSI once the transmit bits are exhausted, and captures the read phase
// from MISO into a right-aligned parallel word.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   start               frame request, taken only in IDLE
//   tgt, rd             target (0 matrix, 1 EEPROM) and read/write
//   opcode/addr/wdata   transmit fields, latched at start
//   rx_len              read bits after the transmit phase (clamped)
//   busy, done          frame in progress / one-cycle end pulse
//   sclk, cs_mtx_n, cs_eep_n, mosi, stop_mosi, miso   SPI pins
//   rx_data             captured read bits
//
// Build option: define HTPA_MOSI_IDLE_HIGH_EN to park MOSI high in IDLE
// and after the transmit phase (EEPROMs wanting an idle-high SI line).
module htpa_spi_frame_seq
  import htpa_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int EEP_ADR_W = 16,
  parameter int EEP_DAT_W = 16,
  parameter int MTX_WR_W  = 8,
  parameter int RX_MAX    = 32,
  parameter int CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tgt,
  input  logic                 rd,
  input  logic [7:0]           opcode,
  input  logic [EEP_ADR_W-1:0] addr,
  input  logic [EEP_DAT_W-1:0] wdata,
  input  logic [CNT_W-1:0]     rx_len,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 cs_mtx_n,
  output logic                 cs_eep_n,
  output logic                 mosi,
  output logic                 stop_mosi,
  input  logic                 miso,
  output logic [RX_MAX-1:0]    rx_data
);

  localparam int TX_W = 8 + EEP_ADR_W + EEP_DAT_W;
  // tmr spans 0..CLK_DIV+1 (HOLD is the longest timed state)
  localparam int TW   = $clog2(CLK_DIV + 2);

`ifdef HTPA_MOSI_IDLE_HIGH_EN
  localparam logic MOSI_IDLE = 1'b1;
`else
  localparam logic MOSI_IDLE = 1'b0;
`endif

  seq_state_e        state, state_n;
  logic [TW-1:0]     tmr;
  logic [CNT_W-1:0]  bit_cnt, tx_len_q, total_q;
  logic [CNT_W-1:0]  tx_len_c, rx_len_c;
  logic [TX_W-1:0]   sr, load_c;
  logic              sck_rise, sck_fall;

  htpa_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_SHIFT),
    .sclk  (sclk),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // Frame sizing and transmit word, evaluated from the live inputs and
  // latched only on an accepted start.
  always_comb begin
    tx_len_c = CNT_W'(8);
    if (tgt == TGT_EEP) begin
      if (rd)
        tx_len_c = (opcode == OP_RDSR) ? CNT_W'(8) : CNT_W'(8 + EEP_ADR_W);
      else if (opcode == OP_WREN || opcode == OP_WRDI || opcode == OP_RDSR)
        tx_len_c = CNT_W'(8);
      else
        tx_len_c = CNT_W'(8 + EEP_ADR_W + EEP_DAT_W);
    end else if (!rd) begin
      tx_len_c = CNT_W'(8 + MTX_WR_W);
    end

    rx_len_c = '0;
    if (rd)
      rx_len_c = (rx_len > CNT_W'(RX_MAX)) ? CNT_W'(RX_MAX) : rx_len;

    load_c = {opcode, addr, wdata};
    if (tgt == TGT_MTX) begin
      load_c = '0;
      load_c[TX_W-1 -: 8+MTX_WR_W] = {opcode, wdata[MTX_WR_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // SHIFT ends on the falling edge that closes bit total-1 (bit_cnt has
  // already been advanced to total by the preceding rising edge).
  // HOLD runs CLK_DIV cycles with CS low, then two CS-high guard cycles.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_SETUP;
      ST_SETUP: if (tmr == TW'(CLK_DIV - 1)) state_n = ST_SHIFT;
      ST_SHIFT: if (sck_fall && bit_cnt == total_q) state_n = ST_HOLD;
      ST_HOLD:  if (tmr == TW'(CLK_DIV + 1)) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state_n != state || !(state == ST_SETUP || state == ST_HOLD))
      tmr <= '0;
    else
      tmr <= tmr + 1'b1;
  end

  assign busy = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_mtx_n  <= 1'b1;
      cs_eep_n  <= 1'b1;
      mosi      <= MOSI_IDLE;
      stop_mosi <= 1'b0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      tx_len_q  <= '0;
      total_q   <= '0;
      sr        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          tx_len_q  <= tx_len_c;
          total_q   <= tx_len_c + rx_len_c;
          sr        <= load_c;
          mosi      <= load_c[TX_W-1];
          bit_cnt   <= '0;
          rx_data   <= '0;
          stop_mosi <= 1'b0;
          cs_mtx_n  <= (tgt != TGT_MTX);
          cs_eep_n  <= (tgt != TGT_EEP);
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt >= tx_len_q)
              rx_data <= {rx_data[RX_MAX-2:0], miso};
          end
          if (sck_fall) begin
            if (bit_cnt == tx_len_q || stop_mosi) begin
              stop_mosi <= 1'b1;
              mosi      <= MOSI_IDLE;
            end else begin
              sr   <= sr << 1;
              mosi <= sr[TX_W-2];
            end
          end
        end
        ST_HOLD: if (tmr == TW'(CLK_DIV - 1)) begin
          cs_mtx_n <= 1'b1;
          cs_eep_n <= 1'b1;
        end
        ST_DONE: begin
          stop_mosi <= 1'b0;
          mosi      <= MOSI_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
